// File: rtl/sdp_pipe_if.sv
// Handshake/data bundle for sdp_pipe; the sig member exists only when SDP_PIPE_SIG_EN is defined.
interface sdp_pipe_if #(parameter int W = 1);
  logic         in_valid;
  logic         in_ready;
  logic         ctl_1;
  logic         ctl_2;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         stall;
  logic         flush;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef SDP_PIPE_SIG_EN
  logic [W-1:0] sig;
`endif

  modport master (
    output in_valid, ctl_1, ctl_2, a, b, c, stall, flush,
`ifdef SDP_PIPE_SIG_EN
    input  sig,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, ctl_1, ctl_2, a, b, c, stall, flush,
`ifdef SDP_PIPE_SIG_EN
    output sig,
`endif
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sdp_pipe.sv
// Pipelined select/datapath unit for the sdp pair: out_data lands 3 un-stalled edges after the accept edge.
// Optional running signature on bus.sig when SDP_PIPE_SIG_EN is defined.
module sdp_alu_bit (
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (op)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b ^ c;
      default: y = (a & b) | (a & c) | (b & c);
    endcase
  end
endmodule

module sdp_pipe #(
  parameter int W = 1
) (
  input logic     clk,
  input logic     reset,
  sdp_pipe_if.slave bus
);
  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } req_t;

  // vld_pipe[0] is the accept register; [1..3] are the three stages. Together
  // they give the 3-edge latency the checker's delay line expects.
  logic [3:0]   vld_pipe;
  req_t         req_in, req_cap, req_s1;
  logic [W-1:0] res_comb, res_s2, res_s3;
  logic         advance;

  assign advance      = !bus.stall;
  assign bus.in_ready = !bus.stall;
  assign req_in       = '{op: {bus.ctl_2, bus.ctl_1}, a: bus.a, b: bus.b, c: bus.c};

  for (genvar i = 0; i < W; i++) begin : g_lane
    sdp_alu_bit u_alu (
      .op (req_s1.op),
      .a  (req_s1.a[i]),
      .b  (req_s1.b[i]),
      .c  (req_s1.c[i]),
      .y  (res_comb[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      req_cap  <= '0;
      req_s1   <= '0;
      res_s2   <= '0;
      res_s3   <= '0;
    end else begin
      if (advance) begin
        vld_pipe <= {vld_pipe[2:0], bus.in_valid};
        req_cap  <= req_in;
        req_s1   <= req_cap;
        res_s2   <= res_comb;
        res_s3   <= res_s2;
      end
      // Flush wins over stall on the valid bits only.
      if (bus.flush) vld_pipe <= '0;
    end
  end

  assign bus.out_valid = vld_pipe[3];
  assign bus.out_data  = res_s3;

`ifdef SDP_PIPE_SIG_EN
  logic [W-1:0] sig_q, sig_rot;

  if (W == 1) begin : g_rot1
    assign sig_rot = sig_q;
  end else begin : g_rotn
    assign sig_rot = {sig_q[W-2:0], sig_q[W-1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      sig_q <= '0;
    else if (advance && !bus.flush && vld_pipe[2])   sig_q <= sig_rot ^ res_s2;
  end

  assign bus.sig = sig_q;
`endif
endmodule
